// File: rtl/bf16_add_arbiter.sv
// bf16_add_arbiter: round-robin sharing of one combinational bf16 adder across NUM_REQ requesters.
// Define BF16_ARB_PIPE_EN to insert an operand register stage in front of the adder (2-cycle latency).
module bf16_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [15:0]            add_a,
  output logic [15:0]            add_b,
  input  logic [15:0]            add_sum,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_sum,
  output logic [ID_W-1:0]        rsp_id
);
  logic [ID_W-1:0]    ptr_q, ptr_d, gnt_id, load_id, rsp_id_q;
  logic [ID_W:0]      idx;
  logic [NUM_REQ-1:0] rot;
  logic               found, gnt, can_accept, rsp_load, rsp_valid_q;
  logic [15:0]        sel_a, sel_b, rsp_sum_q;
  // rot[k] is requester (ptr+k) mod NUM_REQ; the lowest set k wins
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    found = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = {1'b0, ptr_q} + (ID_W+1)'(k);
        idx = (idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx;
        found = 1'b1;
        gnt_id = idx[ID_W-1:0];
      end
    end
  end
  assign gnt       = !rst && can_accept && found;
  assign req_ready = gnt ? NUM_REQ'(1) << gnt_id : '0;
  assign sel_a     = 16'(req_a >> (16 * gnt_id));
  assign sel_b     = 16'(req_b >> (16 * gnt_id));
  assign ptr_d     = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (gnt) ptr_q <= ptr_d;
  end
`ifdef BF16_ARB_PIPE_EN
  logic            s1_valid_q;
  logic [15:0]     s1_a_q, s1_b_q;
  logic [ID_W-1:0] s1_id_q;
  assign rsp_load   = s1_valid_q && (!rsp_valid_q || rsp_ready);
  assign can_accept = !s1_valid_q || rsp_load;
  assign load_id    = s1_id_q;
  assign add_a      = s1_valid_q ? s1_a_q : '0;
  assign add_b      = s1_valid_q ? s1_b_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_id_q <= '0;
    end else if (can_accept) begin
      s1_valid_q <= gnt;
      s1_a_q <= gnt ? sel_a : '0;
      s1_b_q <= gnt ? sel_b : '0;
      s1_id_q <= gnt_id;
    end
  end
`else
  assign rsp_load   = gnt;
  assign can_accept = !rsp_valid_q || rsp_ready;
  assign load_id    = gnt_id;
  assign add_a      = gnt ? sel_a : '0;
  assign add_b      = gnt ? sel_b : '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q <= '0;
      rsp_id_q <= '0;
    end else if (rsp_load) begin
      rsp_valid_q <= 1'b1;
      rsp_sum_q <= add_sum;
      rsp_id_q <= load_id;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_bf16_add_arbiter.sv
// tb_bf16_add_arbiter: directed stimulus, per-cycle behavioural model plus hand-computed literal checks.
module tb_bf16_add_arbiter;
  localparam int N = 4;
`ifdef BF16_ARB_PIPE_EN
  localparam logic PIPE = 1'b1;
`else
  localparam logic PIPE = 1'b0;
`endif
  localparam int LAT     = PIPE ? 2 : 1;
  localparam int HELD_ID = PIPE ? 0 : 1;
  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic [15:0]     add_a, add_b, add_sum, rsp_sum;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  int              n_chk = 0;
  int              n_fail = 0;
  always #5 clk = ~clk;
  // Stand-in for the shared adder: exact bf16 results for the directed pairs, a plain scramble otherwise
  function automatic logic [15:0] fake_add(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3F80 && b == 16'h3F80) return 16'h4000;
    if (a == 16'h4000 && b == 16'hC000) return 16'h0000;
    if (a == 16'h7F80 && b == 16'h3F80) return 16'h7F80;
    return a + b;
  endfunction
  assign add_sum = fake_add(add_a, add_b);
  bf16_add_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_pair(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask
  initial begin : model
    int          ptr, g, out_id, mid_id;
    logic        out_v, mid_v, acc, s2_load;
    logic [15:0] out_sum, mid_a, mid_b, ga, gb;
    ptr = 0; out_v = 1'b0; out_sum = '0; out_id = 0;
    mid_v = 1'b0; mid_a = '0; mid_b = '0; mid_id = 0;
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      s2_load = mid_v && (!out_v || rsp_ready);
      acc = PIPE ? (!mid_v || s2_load) : (!out_v || rsp_ready);
      g = -1;
      if (!rst && acc)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
      ga = '0;
      gb = '0;
      if (g >= 0) begin
        ga = req_a[16*g +: 16];
        gb = req_b[16*g +: 16];
      end
      chk("m_ready", req_ready, g < 0 ? 32'd0 : 32'd1 << g);
      chk("m_add_a", add_a, PIPE ? (mid_v ? mid_a : 16'h0) : ga);
      chk("m_add_b", add_b, PIPE ? (mid_v ? mid_b : 16'h0) : gb);
      chk("m_rsp_valid", rsp_valid, out_v);
      chk("m_rsp_sum", rsp_sum, out_sum);
      chk("m_rsp_id", rsp_id, out_id);
      if (rst) begin
        ptr = 0; out_v = 1'b0; out_sum = '0; out_id = 0; mid_v = 1'b0;
      end else begin
        if (PIPE) begin
          if (s2_load) begin
            out_v = 1'b1; out_sum = fake_add(mid_a, mid_b); out_id = mid_id;
          end else if (rsp_ready) out_v = 1'b0;
          if (acc) begin
            mid_v = (g >= 0); mid_a = ga; mid_b = gb; mid_id = g;
          end
        end else begin
          if (g >= 0) begin
            out_v = 1'b1; out_sum = fake_add(ga, gb); out_id = g;
          end else if (rsp_ready) out_v = 1'b0;
        end
        if (g >= 0) ptr = (g + 1) % N;
      end
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int exp_id, pops;
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_sum", rsp_sum, 0);
    chk("reset_id", rsp_id, 0);
    chk("reset_ready", req_ready, 0);
    step(); rst = 1'b0; req_valid = '0;
    set_pair(2, 16'h3F80, 16'h3F80); req_valid = 4'b0100;
    @(negedge clk); chk("t1_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    repeat (LAT - 1) step();
    @(negedge clk);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_sum", rsp_sum, 16'h4000);
    chk("t1_id", rsp_id, 2);
    step();
    for (int i = 0; i < N; i++) set_pair(i, 16'h4000, 16'hC000);
    req_valid = '1;
    @(negedge clk); chk("t1_ptr", req_ready, 4'b1000);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rr_ready", req_ready, 32'd1 << (i % 4));
      if (i >= LAT) begin
        chk("rr_valid", rsp_valid, 1);
        chk("rr_sum", rsp_sum, 16'h0000);
        chk("rr_id", rsp_id, (i - LAT) % 4);
      end
      step();
    end
    req_valid = 4'b0011; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, HELD_ID);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk); chk("bp_release", req_ready, 4'b0001);
    step(); req_valid = '0;
    repeat (4) step();
    set_pair(1, 16'h7F80, 16'h3F80); req_valid = 4'b0010;
    @(negedge clk); chk("sp_ready", req_ready, 4'b0010);
    step(); req_valid = '0;
    repeat (LAT - 1) step();
    @(negedge clk);
    chk("sp_valid", rsp_valid, 1);
    chk("sp_sum", rsp_sum, 16'h7F80);
    chk("sp_id", rsp_id, 1);
    step(); req_valid = '1; rsp_ready = 1'b0;
    repeat (3) step();
    @(negedge clk); chk("rm_pre_valid", rsp_valid, 1);
    step(); rst = 1'b1;
    step();
    @(negedge clk);
    chk("rm_valid", rsp_valid, 0);
    chk("rm_ready", req_ready, 0);
    step(); rst = 1'b0; rsp_ready = 1'b1;
    @(negedge clk); chk("rm_first", req_ready, 4'b0001);
    step();
    for (int i = 0; i < N; i++) set_pair(i, 16'(32'h1234 + i * 32'h1111), 16'(32'h0F0F * (i + 1)));
    for (int i = 0; i < 12; i++) begin
      rsp_ready = (i % 3) != 0;
      req_valid = 4'(4'b1011 >> (i % 2)) | 4'(i % 5);
      step();
    end
    req_valid = '1; rsp_ready = 1'b1; rst = 1'b1;
    step(); rst = 1'b0;
    exp_id = 0; pops = 0;
    for (int i = 0; i < 12; i++) begin
      rsp_ready = (i != 4);
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        chk("drop_id", rsp_id, exp_id);
        exp_id = (exp_id + 1) % N;
        pops++;
      end
      step();
    end
    chk("drop_pops", pops, 12 - LAT - 1);
    req_valid = '0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
